arch_state_dumper: RTL and testbench

Synthesizable end-of-run state dumper that sits directly downstream of the pipelined CPU core. It counts clock cycles after reset, then freezes the core and streams its architectural state (32 general registers, then 32 data-memory words) out over a valid/ready word stream. The consumer is a UART or trace sink, so a run can be checked on hardware without a simulator.

---
 rtl/arch_dump_pkg.sv | 30 +++
 rtl/dump_out_slice.sv | 41 ++++
 rtl/arch_state_dumper.sv | 173 +++++++++++++++++
 tb/tb_arch_state_dumper.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/arch_dump_pkg.sv
// Shared types and constants for the architectural state dumper.
package arch_dump_pkg;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = 6;
    localparam int unsigned TAG_W = 8;
    localparam int unsigned ADDR_W = 5;

    localparam logic [1:0] KIND_REG = 2'b00;
    localparam logic [1:0] KIND_MEM = 2'b01;
    localparam logic [1:0] KIND_PC  = 2'b10;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DUMP_REG,
        ST_DUMP_MEM,
`ifdef DUMP_PC_EN
        ST_DUMP_PC,
`endif
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Stream tag: kind in the top two bits, word index below.
    function automatic logic [TAG_W-1:0] make_tag(input logic [1:0] kind,
                                                  input logic [IDX_W-1:0] idx);
        return {kind, idx};
    endfunction

endpackage

// File: rtl/dump_out_slice.sv
// Single-entry valid/ready output register carrying data, tag and last.
module dump_out_slice
    import arch_dump_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [TAG_W-1:0]  load_tag,
    input  logic              load_last,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [TAG_W-1:0]  tag,
    output logic              last,
    output logic              slot_free_c
);

    // Slot may take a new word when empty or when the current word leaves this cycle.
    assign slot_free_c = !valid || ready;

    // Hold the word until accepted; load only ever happens into a free slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid <= 1'b0;
            data  <= '0;
            tag   <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            tag   <= load_tag;
            last  <= load_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/arch_state_dumper.sv
// End-of-run dumper: counts cycles, freezes the core, streams RF then DM words.
// Optional build macro DUMP_PC_EN appends a final PC beat to the stream.
module arch_state_dumper
    import arch_dump_pkg::*;
#(
    parameter int unsigned TRIGGER_CYCLE = 30,
    parameter int unsigned NUM_REGS      = 32,
    parameter int unsigned NUM_MEM       = 32,
    parameter int unsigned DATA_W        = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              dump_req_i,
    output logic              freeze_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic [DATA_W-1:0] pc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [TAG_W-1:0]  out_tag_o,
    output logic              out_last_o,
    output logic              done_o
);

    localparam logic [CNT_W-1:0] TRIG_CNT = CNT_W'(TRIGGER_CYCLE - 1);
    localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(NUM_MEM - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic               freeze_q, freeze_d;
    logic               done_q, done_d;

    logic               load;
    logic [DATA_W-1:0]  load_data;
    logic [TAG_W-1:0]   load_tag;
    logic               load_last;
    logic               slot_free_c;

`ifndef DUMP_PC_EN
    logic unused_pc;
    assign unused_pc = ^pc_i;
`endif

    assign freeze_o   = freeze_q;
    assign done_o     = done_q;
    assign reg_addr_o = index_q[ADDR_W-1:0];
    assign mem_addr_o = index_q[ADDR_W-1:0];

    // State, counter and index registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            index_q  <= '0;
            freeze_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            index_q  <= index_d;
            freeze_q <= freeze_d;
            done_q   <= done_d;
        end
    end

    // Next-state, index walk and output-slice load selection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        index_d   = index_q;
        freeze_d  = freeze_q;
        done_d    = done_q;
        load      = 1'b0;
        load_data = '0;
        load_tag  = '0;
        load_last = 1'b0;

        case (state_q)
            ST_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Counter and early request collapse onto the same single transition.
                if ((cnt_q == TRIG_CNT) || dump_req_i) begin
                    state_d  = ST_DUMP_REG;
                    index_d  = '0;
                    freeze_d = 1'b1;
                end
            end

            ST_DUMP_REG: begin
                if (slot_free_c) begin
                    load      = 1'b1;
                    load_data = reg_data_i;
                    load_tag  = make_tag(KIND_REG, index_q);
                    if (index_q == REG_LAST) begin
                        index_d = '0;
                        state_d = ST_DUMP_MEM;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                    end
                end
            end

            ST_DUMP_MEM: begin
                if (slot_free_c) begin
                    load      = 1'b1;
                    load_data = mem_data_i;
                    load_tag  = make_tag(KIND_MEM, index_q);
                    if (index_q == MEM_LAST) begin
`ifdef DUMP_PC_EN
                        state_d   = ST_DUMP_PC;
`else
                        load_last = 1'b1;
                        state_d   = ST_DRAIN;
`endif
                    end else begin
                        index_d = index_q + IDX_W'(1);
                    end
                end
            end

`ifdef DUMP_PC_EN
            ST_DUMP_PC: begin
                if (slot_free_c) begin
                    load      = 1'b1;
                    load_data = pc_i;
                    load_tag  = make_tag(KIND_PC, '0);
                    load_last = 1'b1;
                    state_d   = ST_DRAIN;
                end
            end
`endif

            ST_DRAIN: begin
                // Slot is occupied here, so free means the last word is taken.
                if (slot_free_c) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_DONE;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    dump_out_slice #(
        .DATA_W (DATA_W)
    ) u_slice (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load        (load),
        .load_data   (load_data),
        .load_tag    (load_tag),
        .load_last   (load_last),
        .ready       (out_ready_i),
        .valid       (out_valid_o),
        .data        (out_data_o),
        .tag         (out_tag_o),
        .last        (out_last_o),
        .slot_free_c (slot_free_c)
    );

endmodule

// File: tb/tb_arch_state_dumper.sv
// Directed bench for arch_state_dumper; honours DUMP_PC_EN when defined.
module tb_arch_state_dumper;

    localparam int T = 30;
`ifdef DUMP_PC_EN
    localparam int NB = 65;
`else
    localparam int NB = 64;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        dump_req_i;
    logic        freeze_o;
    logic [4:0]  reg_addr_o;
    logic [31:0] reg_data_i;
    logic [4:0]  mem_addr_o;
    logic [31:0] mem_data_i;
    logic [31:0] pc_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [7:0]  out_tag_o;
    logic        out_last_o;
    logic        done_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign reg_data_i = 32'(reg_addr_o) * 32'd3;
    assign mem_data_i = 32'd100 + 32'(mem_addr_o);
    assign pc_i       = 32'h44;

    arch_state_dumper #(
        .TRIGGER_CYCLE (T),
        .NUM_REGS      (32),
        .NUM_MEM       (32),
        .DATA_W        (32)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .dump_req_i  (dump_req_i),
        .freeze_o    (freeze_o),
        .reg_addr_o  (reg_addr_o),
        .reg_data_i  (reg_data_i),
        .mem_addr_o  (mem_addr_o),
        .mem_data_i  (mem_data_i),
        .pc_i        (pc_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_tag_o   (out_tag_o),
        .out_last_o  (out_last_o),
        .done_o      (done_o)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_tag(input int k);
        if (k < 32)      return 8'(k);
        else if (k < 64) return 8'(8'h40 + 8'(k - 32));
        else             return 8'h80;
    endfunction

    function automatic logic [31:0] exp_data(input int k);
        if (k < 32)      return 32'(3 * k);
        else if (k < 64) return 32'(100 + k - 32);
        else             return 32'h44;
    endfunction

    // Hold reset for two edges; returns #1 after the edge that starts cycle 0.
    task automatic do_reset();
        rst_i       = 1'b1;
        dump_req_i  = 1'b0;
        out_ready_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_i = 1'b0;
    endtask

    // One dump run from cycle 0; abort_after>0 stops once that many beats are accepted.
    task automatic run_scenario(input string nm, input int req_cyc, input bit toggle,
                                input int abort_after, input int exp_freeze);
        int cyc = 0;
        int beats = 0;
        int fr = -1;
        int fv = -1;
        int dn = -1;
        int last_acc = -1;
        bit stall = 1'b0;
        logic [31:0] pd = '0;
        logic [7:0]  pt = '0;
        logic        pl = 1'b0;
        while (dn < 0 && cyc < 400 && !(abort_after > 0 && beats >= abort_after)) begin
            out_ready_i = toggle ? (cyc % 2 == 0) : 1'b1;
            dump_req_i  = (cyc == req_cyc);
            @(negedge clk);
            if (cyc == 0)
                chk({nm, "_rst_vals"},
                    longint'({freeze_o, out_valid_o, out_data_o, out_tag_o, out_last_o,
                              done_o, reg_addr_o, mem_addr_o}), 0);
            if (stall)
                chk({nm, "_stall_hold"},
                    longint'({out_valid_o, out_data_o, out_tag_o, out_last_o}),
                    longint'({1'b1, pd, pt, pl}));
            if (fr < 0 && freeze_o) fr = cyc;
            if (fv < 0 && out_valid_o) fv = cyc;
            if (done_o) dn = cyc;
            if (out_valid_o && out_ready_i) begin
                chk($sformatf("%s_beat%0d", nm, beats),
                    longint'({out_data_o, out_tag_o, out_last_o}),
                    longint'({exp_data(beats), exp_tag(beats), beats == NB - 1}));
                if (beats == NB - 1) last_acc = cyc;
                beats++;
            end
            stall = out_valid_o && !out_ready_i;
            pd = out_data_o;
            pt = out_tag_o;
            pl = out_last_o;
            @(posedge clk);
            #1 cyc++;
        end
        dump_req_i = 1'b0;
        if (abort_after > 0) begin
            chk({nm, "_abort_beats"}, beats, abort_after);
            return;
        end
        chk({nm, "_beats"}, beats, NB);
        chk({nm, "_freeze_cyc"}, fr, exp_freeze);
        chk({nm, "_first_cyc"}, fv, exp_freeze + 1);
        chk({nm, "_done_after_last"}, dn, last_acc + 1);
        if (!toggle) chk({nm, "_last_cyc"}, last_acc, exp_freeze + NB);
        // Idle after completion; a late request must not restart anything.
        for (int i = 0; i < 4; i++) begin
            out_ready_i = 1'b1;
            dump_req_i  = (i == 1);
            @(negedge clk);
            chk($sformatf("%s_post%0d", nm, i),
                longint'({done_o, freeze_o, out_valid_o}), 3'b110);
            @(posedge clk);
            #1;
        end
        dump_req_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        dump_req_i  = 1'b0;
        out_ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("in_reset", longint'({freeze_o, out_valid_o, done_o, out_last_o}), 0);

        do_reset();
        run_scenario("base", -1, 1'b0, 0, T);

        do_reset();
        run_scenario("bp", -1, 1'b1, 0, T);

        do_reset();
        run_scenario("early", 5, 1'b0, 0, 6);

        do_reset();
        run_scenario("simul", T - 1, 1'b0, 0, T);

        do_reset();
        run_scenario("mid_a", -1, 1'b0, 21, T);
        rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        run_scenario("mid_b", -1, 1'b0, 0, T);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
